// File: rtl/pipe_skid_reg_if.sv
// Valid/ready bundle around pipe_skid_reg: upstream and downstream channels.
// slave is the buffer's view; master is the surrounding pipeline's view.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer for pipeline stage boundaries.
// All outputs come from registered state; in_ready never sees out_ready.
module pipe_skid_reg #(
  parameter int              DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  pipe_skid_reg_if.slave bus,
  output logic [1:0]     count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] main_q, main_n;
  logic [DATA_W-1:0] skid_q, skid_n;
  logic              in_xfer, out_xfer;

  assign bus.in_ready  = !rst && (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_q;
  assign count         = state;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = EMPTY;
      main_n  = RST_VAL;
      skid_n  = RST_VAL;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_n = ONE;
            main_n  = bus.in_data;
          end
        end
        ONE: begin
          unique case (1'b1)
            (in_xfer && out_xfer): begin
              main_n = bus.in_data;
            end
            (out_xfer && !in_xfer): begin
              state_n = EMPTY;
              main_n  = RST_VAL;
            end
            (in_xfer && !out_xfer): begin
              state_n = TWO;
              skid_n  = bus.in_data;
            end
            default: ;
          endcase
        end
        TWO: begin
          // Skid drains into main; upstream is already stalled.
          if (out_xfer) begin
            state_n = ONE;
            main_n  = skid_q;
            skid_n  = RST_VAL;
          end
        end
        default: begin
          state_n = EMPTY;
          main_n  = RST_VAL;
          skid_n  = RST_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

endmodule
